// File: rtl/debugger_hex_tx_formatter.sv
// debugger_hex_tx_formatter
// Formats one latched 32-bit word as 8 uppercase ASCII hex digits (MSB nibble
// first). Each word can be framed by optional start/split/stop bytes. The bytes
// are streamed to the debugger UART transmitter one request per byte.
// Optional feature: define DEBUGGER_HEX_TX_CRLF_EN to send CR, LF after the
// stop byte whenever the latched stop enable is set.
module debugger_hex_tx_formatter #(
    parameter logic [7:0] P_START_CHAR = 8'h3C,
    parameter logic [7:0] P_SPLIT_CHAR = 8'h2C,
    parameter logic [7:0] P_STOP_CHAR  = 8'h3E
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iTXD_REQ,
    output logic        oTXD_BUSY,
    input  logic        iTXD_START_EN,
    input  logic        iTXD_SPLIT_EN,
    input  logic        iTXD_STOP_EN,
    input  logic [31:0] iTXD_DATA,
    output logic        oUART_REQ,
    input  logic        iUART_BUSY,
    output logic [7:0]  oUART_DATA
);

    // Slot map: 0 start, 1..8 digit7..digit0, 9 split, 10 stop, 11 CR, 12 LF
    localparam int unsigned SLOTS = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        start_en_q, start_en_d;
    logic        split_en_q, split_en_d;
    logic        stop_en_q, stop_en_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        uart_req_q, uart_req_d;
    logic [7:0]  uart_data_q, uart_data_d;

    logic [SLOTS-1:0] slot_en;
    logic             next_found;
    logic [3:0]       next_slot;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] slot_byte(input logic [3:0] slot, input logic [31:0] d);
        case (slot)
            4'd0:    return P_START_CHAR;
            4'd1:    return hex_char(d[31:28]);
            4'd2:    return hex_char(d[27:24]);
            4'd3:    return hex_char(d[23:20]);
            4'd4:    return hex_char(d[19:16]);
            4'd5:    return hex_char(d[15:12]);
            4'd6:    return hex_char(d[11:8]);
            4'd7:    return hex_char(d[7:4]);
            4'd8:    return hex_char(d[3:0]);
            4'd9:    return P_SPLIT_CHAR;
            4'd10:   return P_STOP_CHAR;
            4'd11:   return 8'h0D;
            4'd12:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // Which slots of the latched word are to be transmitted
    always_comb begin
        slot_en      = '0;
        slot_en[0]   = start_en_q;
        slot_en[8:1] = '1;
        slot_en[9]   = split_en_q;
        slot_en[10]  = stop_en_q;
`ifdef DEBUGGER_HEX_TX_CRLF_EN
        slot_en[11]  = stop_en_q;
        slot_en[12]  = stop_en_q;
`endif
    end

    // First enabled slot at or after the current index; none found means the word is done
    always_comb begin
        next_found = 1'b0;
        next_slot  = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!next_found && slot_en[i] && (i >= {28'd0, idx_q})) begin
                next_found = 1'b1;
                next_slot  = i[3:0];
            end
        end
    end

    // Next-state and output decode for the per-byte handshake sequence
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        start_en_d  = start_en_q;
        split_en_d  = split_en_q;
        stop_en_d   = stop_en_q;
        idx_d       = idx_q;
        uart_req_d  = 1'b0;
        uart_data_d = uart_data_q;

        case (state_q)
            ST_IDLE: begin
                if (iTXD_REQ) begin
                    data_d     = iTXD_DATA;
                    start_en_d = iTXD_START_EN;
                    split_en_d = iTXD_SPLIT_EN;
                    stop_en_d  = iTXD_STOP_EN;
                    idx_d      = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                uart_data_d = slot_byte(next_slot, data_q);
                idx_d       = next_slot + 4'd1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (!iUART_BUSY) begin
                    uart_req_d = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!iUART_BUSY) begin
                    state_d = next_found ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy follows the next state so it drops on the very cycle IDLE is entered
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            start_en_q  <= 1'b0;
            split_en_q  <= 1'b0;
            stop_en_q   <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            uart_req_q  <= 1'b0;
            uart_data_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            start_en_q  <= start_en_d;
            split_en_q  <= split_en_d;
            stop_en_q   <= stop_en_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            uart_req_q  <= uart_req_d;
            uart_data_q <= uart_data_d;
        end
    end

    assign oTXD_BUSY  = busy_q;
    assign oUART_REQ  = uart_req_q;
    assign oUART_DATA = uart_data_q;

endmodule

// File: doc/debugger_hex_tx_formatter.md
Name: debugger_hex_tx_formatter

Overview:
Downstream stage of the processor debugger main controller: it takes one 32-bit register word per request and emits it as ASCII over the byte-wide debugger UART transmitter. Each word becomes 8 uppercase hex digits, MSB nibble first. A start marker, a separator and a stop marker are added around the digits as the controller requests. The block sits between the debugger controller and the UART TX interface and owns the byte-level handshake to it.

Parameters:
P_START_CHAR, 8'h3C, byte sent before the digits when start is enabled ('<')
P_SPLIT_CHAR, 8'h2C, byte sent after the digits when split is enabled (',')
P_STOP_CHAR, 8'h3E, byte sent after the digits/split when stop is enabled ('>')

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iTXD_REQ  in  1  word request; accepted only when oTXD_BUSY=0
oTXD_BUSY  out  1  high from the cycle after acceptance until the last byte's UART handshake completes
iTXD_START_EN  in  1  prepend P_START_CHAR; sampled at acceptance
iTXD_SPLIT_EN  in  1  append P_SPLIT_CHAR; sampled at acceptance
iTXD_STOP_EN  in  1  append P_STOP_CHAR; sampled at acceptance
iTXD_DATA  in  32  word to format; sampled at acceptance
oUART_REQ  out  1  one-cycle byte request to the UART
iUART_BUSY  in  1  UART transmitter busy
oUART_DATA  out  8  byte presented with oUART_REQ

Behaviour:
- Reset (inRESET=0, asynchronous): state IDLE, oTXD_BUSY=0, oUART_REQ=0, oUART_DATA=8'h00, data/enable latches and byte index cleared.
- Reset mid-word abandons the word immediately. No further bytes are emitted, and the bytes already sent are not resent.
- Acceptance: in IDLE with iTXD_REQ=1, latch iTXD_DATA and the three enables, then go to LOAD. oTXD_BUSY is registered and reads 1 starting the next cycle.
- iTXD_REQ while busy is ignored. It is neither queued nor allowed to corrupt the latched word.
- Byte sequence, in order; disabled slots are skipped:
  - start (if enabled)
  - digit7 (bits 31:28) down to digit0 (bits 3:0)
  - split (if enabled)
  - stop (if enabled)
  - CR, LF (optional feature)
- Split and stop both enabled gives digits, split, stop.
- Hex encoding: nibble n < 10 maps to 8'h30+n; n >= 10 maps to 8'h37+n (uppercase 'A'-'F').
- Byte index is a 4-bit counter over the 8 to 13 slots. It walks the slots and skips the disabled ones.
- States:
  - IDLE: wait for a request.
  - LOAD: select the next enabled slot, set oUART_DATA, go to SEND.
  - SEND: if iUART_BUSY=0, pulse oUART_REQ for exactly one cycle and go to GAP; otherwise hold oUART_DATA stable and stay.
  - GAP: one cycle in which iUART_BUSY is ignored, covering the UART's 1-cycle busy latency. Go to WAIT.
  - WAIT: when iUART_BUSY=0, go to LOAD if slots remain, else to IDLE.
- oTXD_BUSY falls on entry to IDLE. A new request can be accepted in that same IDLE cycle.
- oUART_DATA holds its last value between words.
- oUART_REQ is never high in two consecutive cycles.
- Minimum per-byte cost is 4 cycles plus the UART's busy time.

Optional Feature:
- Macro DEBUGGER_HEX_TX_CRLF_EN.
- When defined: whenever the latched stop enable is 1, bytes 8'h0D then 8'h0A are sent immediately after P_STOP_CHAR. The index range extends to 13 slots.
- When undefined: no CR/LF is ever emitted, and the slot counter still needs only 4 bits.

Test Plan:
- Reset defaults: hold inRESET low with iTXD_REQ=1 -> oTXD_BUSY=0, oUART_REQ=0, oUART_DATA=8'h00. Release reset, pulse iTXD_REQ with data 0, no enables, UART idle -> 8 bytes of 8'h30, then oTXD_BUSY=0.
- Full framing: data 32'h12AB00FF, start=1, split=1, stop=0, UART busy 10 cycles per byte -> bytes 3C 31 32 41 42 30 30 46 46 2C in order. Exactly one oUART_REQ pulse per byte, each issued only while iUART_BUSY=0.
- Stop and hex edges: data 32'h9ABCDEF0, stop=1, others 0 -> 39 41 42 43 44 45 46 30 3E. With DEBUGGER_HEX_TX_CRLF_EN defined, 0D 0A follow 3E.
- Back-to-back and ignored request: assert iTXD_REQ with 32'hFFFFFFFF, then again mid-word with 32'h00000000 -> only 8 bytes of 8'h46 are sent. A request on the first IDLE cycle is accepted, and its data then goes out.
- Slow UART: hold iUART_BUSY high 50 cycles before the first byte -> oUART_REQ stays 0, oUART_DATA is held at 8'h3C, oTXD_BUSY=1 throughout.
- Reset mid-word: drop inRESET after the 3rd byte of 32'h12345678 -> all outputs return to reset values at once. After release, no further bytes appear without a new request.
